// File: rtl/button_event_fsm.sv
// button_event_fsm
// Classifies a debounced button level into edge ticks and press events:
// short press, long press and, optionally, double click.
// Build option: define DOUBLE_CLICK_EN to enable the release-gap window
// and double-click detection. Without it, short_press follows the release
// directly and double_click is held at 0.
//
// state          | meaning
// ---------------+------------------------------------------------------
// IDLE           | button released, no event in progress
// PRESSED        | first press held, counting toward the long threshold
// LONG_HELD      | long press already reported, waiting for release
// WAIT_SECOND    | released after a short press, timing the gap
// SECOND_PRESSED | second press seen inside the gap, waiting for release

module button_event_fsm #(
    parameter int LONG_TICKS   = 50_000_000,
    parameter int DCLICK_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise_tick,
    output logic fall_tick,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam int MAX_TICKS = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_PRESSED        = 3'd1;
    localparam logic [2:0] ST_LONG_HELD      = 3'd2;
`ifdef DOUBLE_CLICK_EN
    localparam logic [2:0] ST_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] ST_SECOND_PRESSED = 3'd4;

    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
`endif

    logic             prev;
    logic             rise;
    logic             fall;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_nxt;
    logic             long_nxt;
    logic             dclick_nxt;

    assign rise = btn_in & ~prev;
    assign fall = ~btn_in & prev;

    // The counter holds at all-ones instead of wrapping to zero.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

    // Next-state, counter and event-pulse decisions for the current sample.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        dclick_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = CNT_ONE;
                end
            end

            ST_PRESSED: begin
                // Release is checked first so a release on the threshold
                // sample still counts as a short press.
                if (!btn_in) begin
`ifdef DOUBLE_CLICK_EN
                    state_nxt = ST_WAIT_SECOND;
                    cnt_nxt   = CNT_ONE;
`else
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    short_nxt = 1'b1;
`endif
                end else if (cnt == LONG_LAST) begin
                    state_nxt = ST_LONG_HELD;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            ST_LONG_HELD: begin
                if (!btn_in) begin
                    state_nxt = ST_IDLE;
                end
            end

`ifdef DOUBLE_CLICK_EN
            ST_WAIT_SECOND: begin
                // A press on the timeout sample still wins.
                if (btn_in) begin
                    state_nxt = ST_SECOND_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DCLICK_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    short_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            ST_SECOND_PRESSED: begin
                // Hold length is irrelevant here; no long press from a
                // second press.
                if (!btn_in) begin
                    state_nxt  = ST_IDLE;
                    dclick_nxt = 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, input history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            prev         <= 1'b0;
            rise_tick    <= 1'b0;
            fall_tick    <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            prev         <= btn_in;
            rise_tick    <= rise;
            fall_tick    <= fall;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= dclick_nxt;
            // Registered from the next state so busy tracks the state register.
            busy         <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_button_event_fsm.sv
// tb_button_event_fsm
// Directed button sequences; every expected pulse is queued with the cycle
// it must appear in, and a monitor pops and compares as pulses arrive.
// Honours DOUBLE_CLICK_EN the same way as the design.
`timescale 1ns/1ps

module tb_button_event_fsm;

    localparam int LONG_TICKS   = 100;
    localparam int DCLICK_TICKS = 40;

    localparam int K_RISE   = 0;
    localparam int K_FALL   = 1;
    localparam int K_SHORT  = 2;
    localparam int K_LONG   = 3;
    localparam int K_DCLICK = 4;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic rise_tick;
    logic fall_tick;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    string ev_name [5] = '{"rise_tick", "fall_tick", "short_press", "long_press", "double_click"};

    button_event_fsm #(
        .LONG_TICKS  (LONG_TICKS),
        .DCLICK_TICKS(DCLICK_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int kind, int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_all_low(string tag);
        check_bit({tag, " rise_tick"},    rise_tick,    1'b0);
        check_bit({tag, " fall_tick"},    fall_tick,    1'b0);
        check_bit({tag, " short_press"},  short_press,  1'b0);
        check_bit({tag, " long_press"},   long_press,   1'b0);
        check_bit({tag, " double_click"}, double_click, 1'b0);
        check_bit({tag, " busy"},         busy,         1'b0);
    endtask

    // Drive a level and let n rising edges sample it; returns 1 ns after the last edge.
    task automatic hold(logic val, int n);
        btn_in = val;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse seen must match the head of the expected queue.
    initial begin : monitor
        logic [4:0] p;
        ev_t        e;
        int         n_evt;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                p = {double_click, long_press, short_press, fall_tick, rise_tick};
                n_evt = int'(p[K_SHORT] === 1'b1) + int'(p[K_LONG] === 1'b1) + int'(p[K_DCLICK] === 1'b1);
                if (n_evt != 0) begin
                    checks++;
                    if (n_evt > 1) begin
                        errors++;
                        $display("FAIL event_exclusive: %0d press events high together (cycle %0d), expected at most 1", n_evt, cyc);
                    end
                end
                for (int k = 0; k < 5; k++) begin
                    if (p[k] === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_%s: pulse at cycle %0d, expected none", ev_name[k], cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.kind != k || e.at != cyc) begin
                                errors++;
                                $display("FAIL event_order: got %s at cycle %0d, expected %s at cycle %0d",
                                         ev_name[k], cyc, ev_name[e.kind], e.at);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int c;

        reset  = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_low("reset");
        reset = 1'b0;
        hold(1'b0, 5);

        // Short press: 20 high samples.
        c = cyc;
        push(K_RISE, c + 1);
        push(K_FALL, c + 21);
`ifdef DOUBLE_CLICK_EN
        push(K_SHORT, c + 21 + DCLICK_TICKS - 1);
`else
        push(K_SHORT, c + 21);
`endif
        hold(1'b1, 20);
        check_bit("short busy_held", busy, 1'b1);
        hold(1'b0, 70);
        check_bit("short busy_done", busy, 1'b0);

        // Long press: 150 high samples, threshold on the 100th.
        c = cyc;
        push(K_RISE, c + 1);
        push(K_LONG, c + LONG_TICKS);
        push(K_FALL, c + 151);
        hold(1'b1, 150);
        check_bit("long busy_held", busy, 1'b1);
        hold(1'b0, 10);
        check_bit("long busy_done", busy, 1'b0);

        // Release on the threshold sample: 99 high samples.
        c = cyc;
        push(K_RISE, c + 1);
        push(K_FALL, c + 100);
`ifdef DOUBLE_CLICK_EN
        push(K_SHORT, c + 100 + DCLICK_TICKS - 1);
`else
        push(K_SHORT, c + 100);
`endif
        hold(1'b1, 99);
        hold(1'b0, 60);
        check_bit("threshold busy_done", busy, 1'b0);

        // Two presses: high 10, low 15, high 10, low.
        c = cyc;
        push(K_RISE, c + 1);
        push(K_FALL, c + 11);
`ifndef DOUBLE_CLICK_EN
        push(K_SHORT, c + 11);
`endif
        push(K_RISE, c + 26);
        push(K_FALL, c + 36);
`ifdef DOUBLE_CLICK_EN
        push(K_DCLICK, c + 36);
`else
        push(K_SHORT, c + 36);
`endif
        hold(1'b1, 10);
        hold(1'b0, 15);
        hold(1'b1, 10);
        hold(1'b0, 60);
        check_bit("double busy_done", busy, 1'b0);

        // Reset on cycle 50 of a held press; the still-high level re-presses.
        c = cyc;
        push(K_RISE, c + 1);
        hold(1'b1, 49);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_low("midpress_reset");
        reset = 1'b0;
        push(K_RISE, c + 51);
        push(K_FALL, c + 141);
`ifdef DOUBLE_CLICK_EN
        push(K_SHORT, c + 141 + DCLICK_TICKS - 1);
`else
        push(K_SHORT, c + 141);
`endif
        hold(1'b1, 90);
        check_bit("repress busy_held", busy, 1'b1);
        hold(1'b0, 60);
        check_bit("repress busy_done", busy, 1'b0);

        hold(1'b0, 5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected pulses never seen, next %s at cycle %0d",
                     exp_q.size(), ev_name[exp_q[0].kind], exp_q[0].at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
